// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes,
// SR/Cause bit positions and the EPC victim-address helper.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int IM_LO    = 10;
  localparam int IM_HI    = 15;
  localparam int IP_LO    = 10;
  localparam int IP_HI    = 15;
  localparam int EXC_LO   = 2;
  localparam int EXC_HI   = 6;
  localparam int CAUSE_BD = 31;

  // Victim in a delay slot restarts at the branch; force word alignment.
  function automatic logic [31:0] epc_of(
    input logic [31:0] pc,
    input logic        bd
  );
    logic [31:0] t;
    t = bd ? pc - 32'd4 : pc;
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, sticky TI on match.
// Ports: clk, reset, we_count_i, we_compare_i, wd_i, count_o, compare_o, ti_o.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_count_i,
  input  logic        we_compare_i,
  input  logic [31:0] wd_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = we_count_i ? wd_i : count_q + 32'd1;
    compare_d = we_compare_i ? wd_i : compare_q;
    ti_d      = ti_q;
    // Compare write acknowledges the timer even if it matches now.
    if (we_compare_i)
      ti_d = 1'b0;
    else if (count_q == compare_q && compare_q != 32'd0)
      ti_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, exception and interrupt request.
// Ports: clk, reset, en/cp0_addr/cp0_wd (mtc0), cp0_rd (mfc0),
// vpc/bd_in/exc_code_in/hw_int/eret (M stage), req, epc_out.
// Optional timer (Count/Compare) built when CP0_COUNT_EN is defined.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wd,
  output logic [31:0] cp0_rd,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic [31:0] count_w;
  logic [31:0] compare_w;
  logic        ti_w;
  logic [5:0]  ip_now;
  logic        int_req;
  logic        exc_req;
  logic        we;

  assign ip_now  = hw_int | {ti_w, 5'b0};
  assign int_req = !exl_q && ie_q && |(ip_now & im_q);
  assign exc_req = !exl_q && (exc_code_in != 5'd0);
  assign req     = int_req || exc_req;
  assign we      = en && !req;

`ifdef CP0_COUNT_EN
  cp0_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .we_count_i   (we && cp0_addr == REG_COUNT),
    .we_compare_i (we && cp0_addr == REG_COMPARE),
    .wd_i         (cp0_wd),
    .count_o      (count_w),
    .compare_o    (compare_w),
    .ti_o         (ti_w)
  );
`else
  assign count_w   = 32'd0;
  assign compare_w = 32'd0;
  assign ti_w      = 1'b0;
`endif

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = ip_now;
    exc_d = exc_q;
    epc_d = epc_q;
    if (req) begin
      exl_d = 1'b1;
      bd_d  = bd_in;
      exc_d = int_req ? EXC_INT : exc_code_in;
      epc_d = epc_of(vpc, bd_in);
    end else begin
      unique case (1'b1)
        en && cp0_addr == REG_SR: begin
          im_d  = cp0_wd[IM_HI:IM_LO];
          exl_d = cp0_wd[SR_EXL];
          ie_d  = cp0_wd[SR_IE];
        end
        en && cp0_addr == REG_EPC:
          epc_d = cp0_wd;
        default: ;
      endcase
      if (eret)
        exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    cp0_rd = 32'd0;
    case (cp0_addr)
      REG_SR:
        cp0_rd = {16'b0, im_q, 8'b0, exl_q, ie_q};
      REG_CAUSE:
        cp0_rd = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};
      REG_EPC:     cp0_rd = epc_q;
      REG_PRID:    cp0_rd = PRID;
      REG_COUNT:   cp0_rd = count_w;
      REG_COMPARE: cp0_rd = compare_w;
      default:     cp0_rd = 32'd0;
    endcase
  end

  // Bypass lets "mtc0 EPC; eret" redirect to the freshly written value.
  assign epc_out = (en && cp0_addr == REG_EPC) ? cp0_wd : epc_q;

endmodule
